// File: rtl/param_sync_fifo_pkg.sv
// Shared helpers for param_sync_fifo: count-width function and
// elaboration-time parameter legality checks.
package fifo_pkg;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int unsigned depth,
                                     input int unsigned af_level,
                                     input int unsigned ae_level);
        return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Push/pop handshake and status bundle of param_sync_fifo; master is the
// producer/consumer side, slave is the FIFO itself.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in, clr_err,
        input  data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, clr_err,
        output data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               count, overflow, underflow
    );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// DEPTH x DATA_W storage array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, optional
// first-word-fall-through read and sticky overflow/underflow flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input logic               clk,
    input logic               rstn,
    param_sync_fifo_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("param_sync_fifo: AF_LEVEL or AE_LEVEL out of range");
    end

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              empty, full, wr_ok, rd_ok;
    logic [DATA_W-1:0] rd_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    always_comb begin
        wr_ok       = bus.push && (!full || bus.pop);
        rd_ok       = bus.pop && !empty;
        wr_ptr_d    = wr_ptr_q + PW'(wr_ok);
        rd_ptr_d    = rd_ptr_q + PW'(rd_ok);
        count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
        // A new error in the clearing cycle wins over clr_err.
        overflow_d  = (overflow_q && !bus.clr_err) || (bus.push && !wr_ok);
        underflow_d = (underflow_q && !bus.clr_err) || (bus.pop && !rd_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        assign bus.data_out = empty ? '0 : rd_data;
    end else begin : g_reg_read
        logic [DATA_W-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = rd_ok ? rd_data : dout_q;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign bus.data_out = dout_q;
    end

    assign bus.count        = count_q;
    assign bus.fifo_empty   = empty;
    assign bus.fifo_full    = full;
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a registered-read 8x16 instance and a FWFT 32x4
// instance, each compared every cycle against a queue-based model.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_W(8),  .DEPTH(16)) ifa ();
    param_sync_fifo_if #(.DATA_W(32), .DEPTH(4))  ifb ();

    param_sync_fifo #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
    ) dut_a (
        .clk(clk), .rstn(rstn), .bus(ifa.slave)
    );

    param_sync_fifo #(
        .DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
    ) dut_b (
        .clk(clk), .rstn(rstn), .bus(ifb.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference models: a queue per FIFO plus the sticky flags and read register.
    logic [7:0]  qa[$];
    logic [31:0] qb[$];
    logic [7:0]  ma_dout = '0;
    bit          ma_ovf = 0, ma_udf = 0, mb_ovf = 0, mb_udf = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qa.delete();
            qb.delete();
            ma_dout = '0;
            ma_ovf  = 0;
            ma_udf  = 0;
            mb_ovf  = 0;
            mb_udf  = 0;
        end else begin
            bit wa, ra, wb, rb;
            wa = ifa.push && (qa.size() < 16 || ifa.pop);
            ra = ifa.pop && qa.size() > 0;
            wb = ifb.push && (qb.size() < 4 || ifb.pop);
            rb = ifb.pop && qb.size() > 0;
            ma_ovf = (ma_ovf && !ifa.clr_err) || (ifa.push && !wa);
            ma_udf = (ma_udf && !ifa.clr_err) || (ifa.pop && !ra);
            mb_ovf = (mb_ovf && !ifb.clr_err) || (ifb.push && !wb);
            mb_udf = (mb_udf && !ifb.clr_err) || (ifb.pop && !rb);
            if (ra) ma_dout = qa.pop_front();
            if (wa) qa.push_back(ifa.data_in);
            if (rb) void'(qb.pop_front());
            if (wb) qb.push_back(ifb.data_in);
        end
    end

    always @(negedge clk) begin
        chk("a_count", 64'(ifa.count),        64'(qa.size()));
        chk("a_empty", 64'(ifa.fifo_empty),   64'(qa.size() == 0));
        chk("a_full",  64'(ifa.fifo_full),    64'(qa.size() == 16));
        chk("a_ae",    64'(ifa.almost_empty), 64'(qa.size() <= 2));
        chk("a_af",    64'(ifa.almost_full),  64'(qa.size() >= 14));
        chk("a_ovf",   64'(ifa.overflow),     64'(ma_ovf));
        chk("a_udf",   64'(ifa.underflow),    64'(ma_udf));
        chk("a_dout",  64'(ifa.data_out),     64'(ma_dout));
        chk("b_count", 64'(ifb.count),        64'(qb.size()));
        chk("b_empty", 64'(ifb.fifo_empty),   64'(qb.size() == 0));
        chk("b_full",  64'(ifb.fifo_full),    64'(qb.size() == 4));
        chk("b_ae",    64'(ifb.almost_empty), 64'(qb.size() <= 1));
        chk("b_af",    64'(ifb.almost_full),  64'(qb.size() >= 3));
        chk("b_ovf",   64'(ifb.overflow),     64'(mb_ovf));
        chk("b_udf",   64'(ifb.underflow),    64'(mb_udf));
        chk("b_dout",  64'(ifb.data_out),     (qb.size() > 0) ? 64'(qb[0]) : 64'(0));
    end

    task automatic op_a(input bit p, input bit po, input logic [7:0] d, input bit c);
        ifa.push = p; ifa.pop = po; ifa.data_in = d; ifa.clr_err = c;
        @(posedge clk);
        #1;
        ifa.push = 0; ifa.pop = 0; ifa.clr_err = 0;
    endtask

    task automatic op_b(input bit p, input bit po, input logic [31:0] d, input bit c);
        ifb.push = p; ifb.pop = po; ifb.data_in = d; ifb.clr_err = c;
        @(posedge clk);
        #1;
        ifb.push = 0; ifb.pop = 0; ifb.clr_err = 0;
    endtask

    initial begin
        logic [7:0] exp8;
        int unsigned pp, pq;

        ifa.push = 0; ifa.pop = 0; ifa.data_in = '0; ifa.clr_err = 0;
        ifb.push = 0; ifb.pop = 0; ifb.data_in = '0; ifb.clr_err = 0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset state
        chk("rst_count", 64'(ifa.count), 64'(0));
        chk("rst_empty", 64'(ifa.fifo_empty), 64'(1));
        chk("rst_ae",    64'(ifa.almost_empty), 64'(1));
        chk("rst_dout",  64'(ifa.data_out), 64'(0));
        chk("rst_b_dout", 64'(ifb.data_out), 64'(0));

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            op_a(1, 0, 8'(i), 0);
            if (i == 12) chk("af_at13", 64'(ifa.almost_full), 64'(0));
            if (i == 13) chk("af_at14", 64'(ifa.almost_full), 64'(1));
            if (i == 14) chk("full_at15", 64'(ifa.fifo_full), 64'(0));
        end
        chk("full_16", 64'(ifa.fifo_full), 64'(1));
        chk("count_16", 64'(ifa.count), 64'(16));
        op_a(1, 0, 8'hAA, 0);
        chk("ovf_set", 64'(ifa.overflow), 64'(1));
        chk("ovf_count", 64'(ifa.count), 64'(16));
        op_a(0, 0, 8'h00, 1);
        chk("ovf_clr", 64'(ifa.overflow), 64'(0));
        for (int i = 0; i < 16; i++) begin
            op_a(0, 1, 8'h00, 0);
            chk("pop_order", 64'(ifa.data_out), 64'(i));
        end
        chk("drained", 64'(ifa.fifo_empty), 64'(1));

        // Push+pop at full across pointer wrap
        for (int i = 0; i < 16; i++) op_a(1, 0, 8'(i), 0);
        for (int i = 0; i < 20; i++) begin
            op_a(1, 1, 8'(8'h10 + i), 0);
            exp8 = (i < 16) ? 8'(i) : 8'(8'h10 + i - 16);
            chk("pp_full_data", 64'(ifa.data_out), 64'(exp8));
            chk("pp_full_count", 64'(ifa.count), 64'(16));
            chk("pp_full_ovf", 64'(ifa.overflow), 64'(0));
        end
        for (int i = 0; i < 16; i++) op_a(0, 1, 8'h00, 0);
        chk("wrap_last", 64'(ifa.data_out), 64'(8'h23));

        // Push+pop on empty: pop rejected, push accepted
        op_a(1, 1, 8'h77, 0);
        chk("udf_set", 64'(ifa.underflow), 64'(1));
        chk("udf_count", 64'(ifa.count), 64'(1));
        op_a(0, 0, 8'h00, 1);
        chk("udf_clr", 64'(ifa.underflow), 64'(0));
        op_a(0, 1, 8'h00, 0);
        chk("udf_pop", 64'(ifa.data_out), 64'(8'h77));
        op_a(0, 1, 8'h00, 1);
        chk("udf_clr_race", 64'(ifa.underflow), 64'(1));
        op_a(0, 0, 8'h00, 1);

        // FWFT instance
        op_b(1, 0, 32'hDEADBEEF, 0);
        chk("fwft_data", 64'(ifb.data_out), 64'h0000_0000_DEAD_BEEF);
        chk("fwft_nempty", 64'(ifb.fifo_empty), 64'(0));
        op_b(0, 1, 32'h0, 0);
        chk("fwft_empty", 64'(ifb.fifo_empty), 64'(1));
        chk("fwft_zero", 64'(ifb.data_out), 64'(0));

        // Asynchronous reset mid-stream at count 9
        for (int i = 0; i < 9; i++) op_a(1, 0, 8'(8'h30 + i), 0);
        op_a(0, 1, 8'h00, 0);
        op_a(1, 0, 8'h39, 0);
        chk("pre_rst_count", 64'(ifa.count), 64'(9));
        #3 rstn = 1'b0;
        #1;
        chk("arst_count", 64'(ifa.count), 64'(0));
        chk("arst_empty", 64'(ifa.fifo_empty), 64'(1));
        chk("arst_ae",    64'(ifa.almost_empty), 64'(1));
        chk("arst_af",    64'(ifa.almost_full), 64'(0));
        chk("arst_dout",  64'(ifa.data_out), 64'(0));
        chk("arst_ovf",   64'(ifa.overflow), 64'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        op_a(1, 0, 8'h55, 0);
        op_a(0, 1, 8'h00, 0);
        chk("post_rst_data", 64'(ifa.data_out), 64'(8'h55));

        // Randomised phases biased towards filling, draining and mixed traffic
        for (int ph = 0; ph < 4; ph++) begin
            pp = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 95;
            pq = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 60;
            for (int n = 0; n < 500; n++) begin
                ifa.push    = ($urandom_range(99) < pp);
                ifa.pop     = ($urandom_range(99) < pq);
                ifa.data_in = 8'($urandom);
                ifa.clr_err = ($urandom_range(31) == 0);
                ifb.push    = ($urandom_range(99) < pp);
                ifb.pop     = ($urandom_range(99) < pq);
                ifb.data_in = $urandom;
                ifb.clr_err = ($urandom_range(31) == 0);
                @(posedge clk);
                #1;
            end
        end
        ifa.push = 0; ifa.pop = 0; ifa.clr_err = 0;
        ifb.push = 0; ifb.pop = 0; ifb.clr_err = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
